// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Default GPR address width.
  localparam int RA_W = 5;

  // Width needed to encode a stage number 0..stages (0 = no forward).
  function automatic int fs_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            reg_write;
    logic            mem_read;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// Youngest-match priority encoder over the scoreboard: returns the lowest
// stage number (>= FIRST) whose in-flight instruction writes src, or 0.
module hz_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int RA_W   = pipe_hazard_ctrl_pkg::RA_W,
  parameter int FIRST  = 1,
  parameter int FS_W   = fs_w(STAGES)
) (
  input  sb_entry_t       sb [STAGES],
  input  logic [RA_W-1:0] src,
  input  logic            src_used,
  output logic [FS_W-1:0] stage,
  output logic            is_load
);

  logic [STAGES-1:0] hit;

  // Per-stage match; r0 is hard-wired zero so it never creates a dependency.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_cmp
      assign hit[gi] = (gi + 1 >= FIRST) && src_used && (src != '0) &&
                       sb[gi].valid && sb[gi].reg_write && (sb[gi].dest == src);
    end
  endgenerate

  // Scan oldest to youngest so the youngest (lowest) hit wins.
  always_comb begin
    stage   = '0;
    is_load = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        stage   = FS_W'(i + 1);
        is_load = sb[i].mem_read;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, interlock and forwarding controller. Tracks every instruction past
// ID in a scoreboard shift register and derives stalls, flushes and operand
// forward selects for the ID and EX stages.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter  int STAGES     = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int FWD_EN     = 1,
  parameter  int RA_W       = pipe_hazard_ctrl_pkg::RA_W,
  parameter  int CNT_W      = 32,
  localparam int FS_W       = fs_w(STAGES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_early,
  input  logic [RA_W-1:0]  id_num_write,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [FS_W-1:0]  fwd_a_id,
  output logic [FS_W-1:0]  fwd_b_id,
  output logic [FS_W-1:0]  fwd_a_ex,
  output logic [FS_W-1:0]  fwd_b_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Index i holds stage i+1 (index 0 = EX).
  sb_entry_t       sb_reg [STAGES];
  logic [RA_W-1:0] ex_rs_reg;
  logic [RA_W-1:0] ex_rt_reg;
  logic            ex_use_rs_reg;
  logic            ex_use_rt_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] flush_count_reg;

  logic [FS_W-1:0] id_k_a, id_k_b, ex_k_a, ex_k_b;
  logic            id_ld_a, id_ld_b, ex_ld_a, ex_ld_b;
  logic            stall_a, stall_b, stall;
  logic [FS_W-1:0] fwd_a_id_next, fwd_b_id_next;
  logic            advance;
  logic            issue;
  sb_entry_t       entry_next;

  // Decide stall and forward select for one ID source given its youngest
  // producer stage k (0 = none). Result is {stall, fwd}.
  function automatic logic [FS_W:0] resolve(input logic [FS_W-1:0] k,
                                            input logic is_load,
                                            input logic early);
    int              thr;
    logic            stall_k;
    logic [FS_W-1:0] fwd_k;
    thr     = is_load ? LOAD_STAGE + 1 : 2;
    stall_k = 1'b0;
    fwd_k   = '0;
    if (k != '0) begin
      if (FWD_EN == 0) begin
        stall_k = 1'b1;
      end else begin
        if (int'(k) >= thr) fwd_k = k;
        // An EX consumer can take the value one stage later than an early one.
        stall_k = early ? (int'(k) < thr) : (int'(k) + 1 < thr);
      end
    end
    return {stall_k, fwd_k};
  endfunction

  // EX forward select; a load still short of its data stage is never chosen.
  function automatic logic [FS_W-1:0] ex_fwd(input logic [FS_W-1:0] k,
                                             input logic is_load);
    if (FWD_EN == 0) return '0;
    if (is_load && (int'(k) < LOAD_STAGE + 1)) return '0;
    return k;
  endfunction

  hz_match #(.STAGES(STAGES), .RA_W(RA_W), .FIRST(1), .FS_W(FS_W)) u_match_id_a (
    .sb(sb_reg), .src(id_rs), .src_used(id_valid & id_use_rs),
    .stage(id_k_a), .is_load(id_ld_a)
  );

  hz_match #(.STAGES(STAGES), .RA_W(RA_W), .FIRST(1), .FS_W(FS_W)) u_match_id_b (
    .sb(sb_reg), .src(id_rt), .src_used(id_valid & id_use_rt),
    .stage(id_k_b), .is_load(id_ld_b)
  );

  hz_match #(.STAGES(STAGES), .RA_W(RA_W), .FIRST(2), .FS_W(FS_W)) u_match_ex_a (
    .sb(sb_reg), .src(ex_rs_reg), .src_used(ex_use_rs_reg),
    .stage(ex_k_a), .is_load(ex_ld_a)
  );

  hz_match #(.STAGES(STAGES), .RA_W(RA_W), .FIRST(2), .FS_W(FS_W)) u_match_ex_b (
    .sb(sb_reg), .src(ex_rt_reg), .src_used(ex_use_rt_reg),
    .stage(ex_k_b), .is_load(ex_ld_b)
  );

  // Combine per-source hazards into the stall and ID forward selects.
  always_comb begin
    {stall_a, fwd_a_id_next} = resolve(id_k_a, id_ld_a, id_early);
    {stall_b, fwd_b_id_next} = resolve(id_k_b, id_ld_b, id_early);
    stall = stall_a | stall_b;
  end

  // Pipeline control with priority hold > stall > redirect.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!hold) begin
      if (stall) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = id_redirect;
      end
    end
  end

  assign fwd_a_id    = fwd_a_id_next;
  assign fwd_b_id    = fwd_b_id_next;
  assign fwd_a_ex    = ex_fwd(ex_k_a, ex_ld_a);
  assign fwd_b_ex    = ex_fwd(ex_k_b, ex_ld_b);
  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

  assign advance = !hold;
  assign issue   = id_valid && !stall;

  // Entry entering EX: the ID instruction, or a bubble when stalled/empty.
  always_comb begin
    entry_next = '0;
    if (issue) begin
      entry_next.valid     = 1'b1;
      entry_next.dest      = id_num_write;
      entry_next.reg_write = id_reg_write;
      entry_next.mem_read  = id_mem_read;
    end
  end

  // Stage 1 of the scoreboard is loaded from ID.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_reg[0] <= '0;
    end else if (advance) begin
      sb_reg[0] <= entry_next;
    end
  end

  // Older stages shift down one place per advancing cycle.
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
      always_ff @(posedge clock) begin
        if (reset) begin
          sb_reg[gi] <= '0;
        end else if (advance) begin
          sb_reg[gi] <= sb_reg[gi-1];
        end
      end
    end
  endgenerate

  // Capture the source operands of the instruction moving into EX.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_rs_reg     <= '0;
      ex_rt_reg     <= '0;
      ex_use_rs_reg <= 1'b0;
      ex_use_rt_reg <= 1'b0;
    end else if (advance) begin
      ex_rs_reg     <= id_rs;
      ex_rt_reg     <= id_rt;
      ex_use_rs_reg <= issue && id_use_rs;
      ex_use_rt_reg <= issue && id_use_rt;
    end
  end

  // Wrapping stall and redirect-flush event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else if (advance) begin
      if (stall) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end else if (id_redirect) begin
        flush_count_reg <= flush_count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, interlock and forwarding controller for the next-generation pipelined CPU. It merges load-use stall detection, ID-stage and EX-stage forward-select generation and redirect flushing into one block. It tracks every in-flight instruction after ID in an internal scoreboard shift register, so stage count, load latency and forwarding mode are build-time choices. It sits beside the ID stage and drives the PC enable, the IF/ID and ID/EX control inputs and the per-stage operand muxes.

## Interface
- STAGES, 3: number of stages after ID (stage 1 = EX … stage STAGES = WB, which writes the GPR at its closing edge); ≥2.
- LOAD_STAGE, 2: stage whose output register first holds load data; 1 ≤ LOAD_STAGE < STAGES.
- FWD_EN, 1: 1 = full forwarding; 0 = interlock-only, all forward selects forced to 0.
- RA_W, 5: register address width.
- CNT_W, 32: performance counter width.
- FS_W = $clog2(STAGES+1): derived forward-select width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- hold  in  1  global freeze (external memory wait)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read
- id_early  in  1  operands needed in ID (branch compare, jr)
- id_num_write  in  RA_W  ID destination register
- id_reg_write  in  1  ID instruction writes GPR
- id_mem_read  in  1  ID instruction is a load
- id_redirect  in  1  branch taken / jump resolved in ID
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  squash IF/ID
- id_ex_flush  out  1  insert bubble into ID/EX
- fwd_a_id, fwd_b_id  out  FS_W  ID operand select; 0 = GPR, k = stage-k result
- fwd_a_ex, fwd_b_ex  out  FS_W  EX operand select; 0 = ID/EX data, k = stage-k result
- stall_count, flush_count  out  CNT_W  wrapping event counters

## Operation
- Scoreboard entry per stage k: valid, dest, reg_write, mem_read. Match(k, r) = valid & reg_write & dest==r & r!=0.
- Availability: avail(k) = k ≥ (mem_read ? LOAD_STAGE+1 : 2).
- Per used source of ID (id_valid=1), find the youngest (lowest) matching k.
  - FWD_EN=1, id_early=1: stall if !avail(k); otherwise fwd_*_id = k.
  - FWD_EN=1, id_early=0: stall if k+1 < availability threshold (load: k+1 < LOAD_STAGE+1). fwd_*_id = k if avail(k), else 0.
  - FWD_EN=0: stall on any match in 1..STAGES.
  - No match: fwd_*_id = 0.
- The unit registers the EX instruction's rs/rt/use bits. fwd_*_ex is the youngest matching stage in 2..STAGES, else 0 (FWD_EN=0: always 0).
- Priority hold > stall > redirect:
  - hold: pc_write = if_id_write = 0, flushes 0, scoreboard, EX regs and counters frozen.
  - stall: pc_write = if_id_write = 0, id_ex_flush = 1, id_redirect ignored, stall_count +1.
  - redirect without stall: if_id_flush = 1, flush_count +1.
  - Otherwise pc_write = if_id_write = 1.
- Advance when hold=0: stage k+1 ← stage k; stage STAGES drops out. Stage 1 ← ID info if id_valid & !stall, else bubble (valid=0).

## Timing
- Hazard, flush and fwd_*_id outputs are combinational from the scoreboard and ID inputs in the same cycle. fwd_*_ex is combinational from registered state.
- Reset (synchronous): scoreboard and EX regs invalid, counters 0. Outputs after reset: pc_write = if_id_write = 1, flushes 0, all fwd 0.
- Reset asserted mid-stall discards all in-flight state; the first cycle after reset never stalls.
- Load-use penalty (defaults): 1 cycle for an EX consumer, 2 for an early consumer. ALU→early penalty: 1. FWD_EN=0: STAGES cycles.
- Counters wrap at 2^CNT_W.

## Structure
- A shared package holds RA_W, the FS_W function and the scoreboard-entry struct (valid, dest, reg_write, mem_read).
- One sub-module, hz_match: a parametrised youngest-match priority encoder. It is instantiated four times (ID rs/rt, EX rs/rt).

## Test plan
- add r1 then add r2,r1,r3 back-to-back -> no stall; next cycle fwd_a_ex=2.
- lw r1 then add using r1 as rt -> one cycle of pc_write=0, id_ex_flush=1, stall_count=1; then fwd_b_ex=3.
- add r1 then beq r1 (id_early=1) -> one stall; then fwd_a_id=2. With lw r1 instead -> two stalls, then fwd_a_id=3.
- id_redirect=1 during a load-use stall -> if_id_flush=0; asserted again the cycle after the stall clears -> if_id_flush=1, flush_count=1.
- hold=1 for 3 cycles during a lw→add hazard -> scoreboard frozen and counters unchanged; on release exactly one stall occurs.
- Destination r0 never forwards or stalls. FWD_EN=0 with add r1→add r1 -> 3 stall cycles, all fwd outputs 0.
